// File: rtl/ghost_mode_scheduler_if.sv
// ghost_mode_scheduler_if: game-control inputs and ghost-mode outputs.
// Ports: tick/start/power_pellet/pacman_dead in; mode/enable/freeze/fright_ending/round_reset out.
interface ghost_mode_scheduler_if;
  logic       tick;
  logic       start;
  logic       power_pellet;
  logic       pacman_dead;
  logic [1:0] ghost_mode;
  logic [3:0] enable_ghosts;
  logic       freeze;
  logic       fright_ending;
  logic       round_reset;

  modport master (
    output tick, start, power_pellet, pacman_dead,
    input  ghost_mode, enable_ghosts, freeze,
    input  fright_ending, round_reset
  );

  modport slave (
    input  tick, start, power_pellet, pacman_dead,
    output ghost_mode, enable_ghosts, freeze,
    output fright_ending, round_reset
  );
endinterface

// File: rtl/ghost_mode_scheduler.sv
// ghost_mode_scheduler: round sequencer (ready/scatter-chase/fright/death).
// Ports: clk_50mhz, reset (async high), gms (slave: tick/start/pellet/dead -> mode outputs).
module ghost_mode_scheduler #(
  parameter int CNT_W         = 10,
  parameter int READY_TICKS   = 72,
  parameter int SCATTER_TICKS = 168,
  parameter int CHASE_TICKS   = 480,
  parameter int SC_ROUNDS     = 4,
  parameter int FRIGHT_TICKS  = 144,
  parameter int FRIGHT_WARN   = 48,
  parameter int RELEASE_GAP   = 48,
  parameter int DEATH_TICKS   = 72
) (
  input logic                   clk_50mhz,
  input logic                   reset,
  ghost_mode_scheduler_if.slave gms
);
  localparam int PH_W = $clog2(2*SC_ROUNDS+1);

  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] RDY_L  = CNT_W'(READY_TICKS);
  localparam logic [CNT_W-1:0] SCAT_L = CNT_W'(SCATTER_TICKS);
  localparam logic [CNT_W-1:0] CHS_L  = CNT_W'(CHASE_TICKS);
  localparam logic [CNT_W-1:0] FRT_L  = CNT_W'(FRIGHT_TICKS);
  localparam logic [CNT_W-1:0] WARN_L = CNT_W'(FRIGHT_WARN);
  localparam logic [CNT_W-1:0] GAP_L  = CNT_W'(RELEASE_GAP);
  localparam logic [CNT_W-1:0] DTH_L  = CNT_W'(DEATH_TICKS);
  localparam logic [PH_W-1:0]  LAST   = PH_W'(2*SC_ROUNDS);

  localparam logic [1:0] M_SCAT = 2'b00;
  localparam logic [1:0] M_CHS  = 2'b01;
  localparam logic [1:0] M_FRT  = 2'b10;
  localparam logic [1:0] M_FRZ  = 2'b11;

  typedef enum logic [2:0] {
    IDLE, READY, RUN, FRIGHT, DYING
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] tmr_q, tmr_d;
  logic [CNT_W-1:0] phc_q, phc_d;
  logic [CNT_W-1:0] rel_q, rel_d;
  logic [PH_W-1:0]  ph_q, ph_d;
  logic [3:0]       en_q, en_d;
  logic [1:0]       mode_q, mode_d;
  logic             frz_q, frz_d;
  logic             fe_q, fe_d;
  logic             rr_q, rr_d;

  logic [CNT_W-1:0] tmr_dec, phc_dec, rel_dec;
  logic [PH_W-1:0]  ph_inc;

  // Odd phases chase; the final phase is permanent chase.
  function automatic logic [1:0] mode_of(input logic [PH_W-1:0] p);
    return (p[0] || p == LAST) ? M_CHS : M_SCAT;
  endfunction

  assign tmr_dec = tmr_q - ONE;
  assign phc_dec = phc_q - ONE;
  assign rel_dec = rel_q - ONE;
  assign ph_inc  = ph_q + PH_W'(1);

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    phc_d   = phc_q;
    rel_d   = rel_q;
    ph_d    = ph_q;
    en_d    = en_q;
    mode_d  = mode_q;
    frz_d   = frz_q;
    fe_d    = fe_q;
    rr_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gms.start) begin
          state_d = READY;
          tmr_d   = RDY_L;
        end
      end
      READY: begin
        if (gms.tick) begin
          if (tmr_q == ONE) begin
            state_d = RUN;
            ph_d    = '0;
            phc_d   = SCAT_L;
            en_d    = 4'b0001;
            rel_d   = GAP_L;
            mode_d  = M_SCAT;
            frz_d   = 1'b0;
          end else begin
            tmr_d = tmr_dec;
          end
        end
      end
      RUN, FRIGHT: begin
        // Events win over a coincident tick; death wins over pellet.
        if (gms.pacman_dead) begin
          state_d = DYING;
          tmr_d   = DTH_L;
          mode_d  = M_FRZ;
          frz_d   = 1'b1;
          fe_d    = 1'b0;
        end else if (gms.power_pellet) begin
          state_d = FRIGHT;
          tmr_d   = FRT_L;
          mode_d  = M_FRT;
          fe_d    = (FRT_L <= WARN_L);
        end else if (gms.tick) begin
          if (en_q != 4'b1111) begin
            if (rel_q == ONE) begin
              en_d  = {en_q[2:0], 1'b1};
              rel_d = GAP_L;
            end else begin
              rel_d = rel_dec;
            end
          end
          // Phase timer is frozen while frightened.
          if (state_q == FRIGHT) begin
            if (tmr_q == ONE) begin
              state_d = RUN;
              mode_d  = mode_of(ph_q);
              fe_d    = 1'b0;
            end else begin
              tmr_d = tmr_dec;
              fe_d  = (tmr_dec <= WARN_L);
            end
          end else if (ph_q != LAST) begin
            if (phc_q == ONE) begin
              ph_d   = ph_inc;
              phc_d  = ph_inc[0] ? CHS_L : SCAT_L;
              mode_d = mode_of(ph_inc);
            end else begin
              phc_d = phc_dec;
            end
          end
        end
      end
      DYING: begin
        if (gms.tick) begin
          if (tmr_q == ONE) begin
            state_d = READY;
            tmr_d   = RDY_L;
            rr_d    = 1'b1;
            en_d    = 4'b0000;
            ph_d    = '0;
          end else begin
            tmr_d = tmr_dec;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_50mhz or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      phc_q   <= '0;
      rel_q   <= '0;
      ph_q    <= '0;
      en_q    <= 4'b0000;
      mode_q  <= M_FRZ;
      frz_q   <= 1'b1;
      fe_q    <= 1'b0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      phc_q   <= phc_d;
      rel_q   <= rel_d;
      ph_q    <= ph_d;
      en_q    <= en_d;
      mode_q  <= mode_d;
      frz_q   <= frz_d;
      fe_q    <= fe_d;
      rr_q    <= rr_d;
    end
  end

  assign gms.ghost_mode    = mode_q;
  assign gms.enable_ghosts = en_q;
  assign gms.freeze        = frz_q;
  assign gms.fright_ending = fe_q;
  assign gms.round_reset   = rr_q;
endmodule

// File: tb/tb_ghost_mode_scheduler.sv
// tb_ghost_mode_scheduler: directed + random stimulus vs. a tick-level model.
// Drives the interface master side; checks all outputs every cycle.
module tb_ghost_mode_scheduler;
  localparam int RDY  = 3;
  localparam int SCAT = 4;
  localparam int CHS  = 6;
  localparam int R    = 2;
  localparam int FRT  = 5;
  localparam int WARN = 2;
  localparam int GAP  = 2;
  localparam int DTH  = 3;

  localparam int S_IDLE = 0;
  localparam int S_RDY  = 1;
  localparam int S_RUN  = 2;
  localparam int S_FRT  = 3;
  localparam int S_DIE  = 4;

  logic clk = 1'b0;
  logic rst;

  ghost_mode_scheduler_if gif ();

  ghost_mode_scheduler #(
    .CNT_W(10), .READY_TICKS(RDY), .SCATTER_TICKS(SCAT),
    .CHASE_TICKS(CHS), .SC_ROUNDS(R), .FRIGHT_TICKS(FRT),
    .FRIGHT_WARN(WARN), .RELEASE_GAP(GAP), .DEATH_TICKS(DTH)
  ) dut (
    .clk_50mhz(clk),
    .reset(rst),
    .gms(gif.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d, expected %0d",
               tag, $time, got, exp);
    end
  endtask

  // Model: game stage, ticks left in stage, phase index and
  // ticks left in it, ghosts released and ticks to the next release.
  int m_st, m_left, m_ph, m_ph_left, m_gh, m_gap;
  bit m_rr;

  task automatic model_reset();
    m_st = S_IDLE; m_left = 0; m_ph = 0;
    m_ph_left = 0; m_gh = 0; m_gap = 0; m_rr = 0;
  endtask

  task automatic model_step(input bit t, input bit s,
                            input bit p, input bit d);
    m_rr = 0;
    case (m_st)
      S_IDLE: if (s) begin m_st = S_RDY; m_left = RDY; end
      S_RDY: if (t) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_st = S_RUN; m_ph = 0; m_ph_left = SCAT;
          m_gh = 1; m_gap = GAP;
        end
      end
      S_RUN, S_FRT: begin
        if (d) begin
          m_st = S_DIE; m_left = DTH;
        end else if (p) begin
          m_st = S_FRT; m_left = FRT;
        end else if (t) begin
          if (m_gh < 4) begin
            m_gap = m_gap - 1;
            if (m_gap == 0) begin m_gh++; m_gap = GAP; end
          end
          if (m_st == S_FRT) begin
            m_left = m_left - 1;
            if (m_left == 0) m_st = S_RUN;
          end else if (m_ph < 2*R) begin
            m_ph_left = m_ph_left - 1;
            if (m_ph_left == 0) begin
              m_ph++;
              m_ph_left = (m_ph % 2 == 1) ? CHS : SCAT;
            end
          end
        end
      end
      S_DIE: if (t) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_st = S_RDY; m_left = RDY; m_rr = 1;
          m_gh = 0; m_ph = 0;
        end
      end
      default: ;
    endcase
  endtask

  function automatic int exp_mode();
    if (m_st == S_FRT) return 2;
    if (m_st == S_RUN)
      return (m_ph % 2 == 1 || m_ph == 2*R) ? 1 : 0;
    return 3;
  endfunction

  task automatic cmp_all();
    check("mode", 32'(gif.ghost_mode), exp_mode());
    check("enable", 32'(gif.enable_ghosts), (1 << m_gh) - 1);
    check("freeze", 32'(gif.freeze),
          (m_st == S_RUN || m_st == S_FRT) ? 0 : 1);
    check("fright_ending", 32'(gif.fright_ending),
          (m_st == S_FRT && m_left <= WARN) ? 1 : 0);
    check("round_reset", 32'(gif.round_reset), 32'(m_rr));
  endtask

  task automatic cyc(input bit t, input bit s,
                     input bit p, input bit d);
    gif.tick = t; gif.start = s;
    gif.power_pellet = p; gif.pacman_dead = d;
    @(posedge clk);
    model_step(t, s, p, d);
    #1;
    cmp_all();
  endtask

  // Async reset away from any edge; start held high is ignored.
  task automatic do_reset();
    gif.start = 1'b1; gif.tick = 1'b1;
    gif.power_pellet = 1'b0; gif.pacman_dead = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_mode", 32'(gif.ghost_mode), 3);
    check("rst_enable", 32'(gif.enable_ghosts), 0);
    check("rst_freeze", 32'(gif.freeze), 1);
    cmp_all();
    @(posedge clk);
    #1;
    cmp_all();
    rst = 1'b0;
    gif.start = 1'b0; gif.tick = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    gif.tick = 1'b0; gif.start = 1'b0;
    gif.power_pellet = 1'b0; gif.pacman_dead = 1'b0;
    #2;
    do_reset();

    cyc(0, 1, 0, 0);
    repeat (RDY) cyc(1, 0, 0, 0);
    check("t1_mode", 32'(gif.ghost_mode), 0);
    check("t1_freeze", 32'(gif.freeze), 1'b0);
    check("t1_enable", 32'(gif.enable_ghosts), 1);

    repeat (24) cyc(1, 0, 0, 0);
    check("t2_chase_forever", 32'(gif.ghost_mode), 1);
    check("t2_enable_all", 32'(gif.enable_ghosts), 15);

    #2;
    do_reset();

    cyc(0, 1, 0, 0);
    repeat (RDY) cyc(1, 0, 0, 0);
    repeat (2) cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 0);
    check("t3_fright", 32'(gif.ghost_mode), 2);
    repeat (3) cyc(1, 0, 0, 0);
    check("t3_fright_end", 32'(gif.fright_ending), 1);
    cyc(1, 0, 1, 0);
    check("t4_reload_fe", 32'(gif.fright_ending), 0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 1, 1);
    check("t5_dying_mode", 32'(gif.ghost_mode), 3);
    check("t5_dying_frz", 32'(gif.freeze), 1);
    repeat (DTH - 1) cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    check("t5_round_reset", 32'(gif.round_reset), 1);
    check("t5_enable", 32'(gif.enable_ghosts), 0);
    cyc(0, 1, 0, 1);
    cyc(1, 1, 1, 1);
    repeat (RDY - 1) cyc(1, 0, 0, 0);
    check("t5_restart_mode", 32'(gif.ghost_mode), 0);
    check("t5_restart_en", 32'(gif.enable_ghosts), 1);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 999) == 0) begin
        #2;
        do_reset();
      end
      cyc(1'($urandom_range(0, 1)),
          $urandom_range(0, 7) == 0,
          $urandom_range(0, 39) == 0,
          $urandom_range(0, 79) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
